// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// datapath width, funct3 operation codes and FSM state encoding.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add multiply or restoring
// divide over XLEN cycles, then a sign-fix cycle and a one-cycle write-back pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            wr_en_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam int AW = 2 * XLEN + 1;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg;
    logic [2:0]        funct3_reg;
    logic [4:0]        rd_lat_reg;
    logic [4:0]        rd_out_reg;
    logic              sign_a_reg, sign_b_reg;
    logic [XLEN-1:0]   opd_reg;
    logic [AW-1:0]     acc_reg, acc_step;
    logic [XLEN-1:0]   result_reg;

    // Operand decode at acceptance
    logic              accept;
    logic              signed_a, signed_b, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_result;

    always_comb begin
        accept   = (state_reg == ST_IDLE) && start_i;
        signed_a = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU)
                || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        signed_b = (funct3_i == F3_MUL) || (funct3_i == F3_MULH)
                || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        neg_a    = signed_a && rs1_data_i[XLEN-1];
        neg_b    = signed_b && rs2_data_i[XLEN-1];
        mag_a    = neg_a ? (~rs1_data_i + 1'b1) : rs1_data_i;
        mag_b    = neg_b ? (~rs2_data_i + 1'b1) : rs2_data_i;
        div_zero = funct3_i[2] && (rs2_data_i == '0);
        div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM))
                && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                && (rs2_data_i == '1);
        fast     = div_zero || div_ovf;
        fast_result = '0;
        if (div_zero) begin
            fast_result = funct3_i[1] ? rs1_data_i : '1;
        end else if (div_ovf) begin
            fast_result = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    // Multiply layout: {carry, high, low/multiplier}; divide: {remainder(XLEN+1), quotient}.
    logic [XLEN:0]   mul_sum;
    logic [XLEN+1:0] rem_sub;
    logic            rem_ge;
    logic [XLEN:0]   rem_new;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opd_reg} : '0);
        rem_sub  = {acc_reg[2*XLEN:XLEN], acc_reg[XLEN-1]} - {2'b00, opd_reg};
        rem_ge   = ~rem_sub[XLEN+1];
        rem_new  = rem_ge ? rem_sub[XLEN:0] : {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        if (funct3_reg[2]) begin
            acc_step = {rem_new, acc_reg[XLEN-2:0], rem_ge};
        end else begin
            acc_step = {1'b0, mul_sum, acc_reg[XLEN-1:1]};
        end
    end

    // Sign correction and result select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, sel_result;

    always_comb begin
        prod_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg[2*XLEN-1:0] + 1'b1) : acc_reg[2*XLEN-1:0];
        quot_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
        rem_fix  = sign_a_reg ? (~acc_reg[2*XLEN-1:XLEN] + 1'b1) : acc_reg[2*XLEN-1:XLEN];
        case (funct3_reg)
            F3_MUL:                        sel_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  sel_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               sel_result = quot_fix;
            default:                       sel_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_next = fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_reg == CW'(XLEN - 1)) begin
                    state_next = ST_SIGN;
                end
            end
            ST_SIGN: state_next = ST_DONE;
            ST_DONE: begin
                done_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        wr_en_o = done_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            funct3_reg <= '0;
            rd_lat_reg <= '0;
            rd_out_reg <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            opd_reg    <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else if (accept) begin
            cnt_reg    <= '0;
            funct3_reg <= funct3_i;
            rd_lat_reg <= rd_addr_i;
            sign_a_reg <= neg_a;
            sign_b_reg <= neg_b;
            // Multiply adds the multiplicand into the high half; divide subtracts the divisor.
            opd_reg    <= funct3_i[2] ? mag_b : mag_a;
            acc_reg    <= {{(XLEN+1){1'b0}}, (funct3_i[2] ? mag_a : mag_b)};
            if (fast) begin
                result_reg <= fast_result;
                rd_out_reg <= rd_addr_i;
            end
        end else if (state_reg == ST_CALC) begin
            acc_reg <= acc_step;
            cnt_reg <= cnt_reg + 1'b1;
        end else if (state_reg == ST_SIGN) begin
            result_reg <= sel_result;
            rd_out_reg <= rd_lat_reg;
        end
    end

    assign result_o  = result_reg;
    assign rd_addr_o = rd_out_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: result values, latency,
// busy/done timing, fast paths, start-ignore and mid-operation reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o;
    logic        done_o;
    logic        wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] result_o;

    int checks;
    int failures;

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .wr_en_o    (wr_en_o),
        .rd_addr_o  (rd_addr_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the idle cycle after done.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_cnt;
        bit seen;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        wen;
        lat = 0; busy_cnt = 0; seen = 0; res = '0; rdo = '0; wen = 1'b0;
        funct3_i   = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = rd;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        rd_addr_i  = 5'($urandom);
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy_o) busy_cnt++;
            if (done_o) begin
                seen = 1;
                res  = result_o;
                rdo  = rd_addr_o;
                wen  = wr_en_o;
            end
        end
        $display("op %s f3=%0d a=%h b=%h result=%h rd=%0d latency=%0d", tag, f3, a, b, res, rdo, lat);
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".result"}, res, exp);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".rd"}, 32'(rdo), 32'(rd));
        check({tag, ".wr_en"}, 32'(wen), 32'd1);
        check({tag, ".busy_cycles"}, busy_cnt, exp_lat);
        @(negedge clk);
        check({tag, ".idle_after"}, {30'd0, busy_o, done_o}, 32'd0);
    endtask

    initial begin
        int dones;
        int wr_cnt;
        logic [31:0] res;
        checks = 0; failures = 0;
        rst = 1'b1; start_i = 1'b0; funct3_i = '0;
        rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
        repeat (2) @(negedge clk);
        check("reset.busy", 32'(busy_o), 32'd0);
        check("reset.done", 32'(done_o), 32'd0);
        check("reset.wr_en", 32'(wr_en_o), 32'd0);
        check("reset.rd", 32'(rd_addr_o), 32'd0);
        check("reset.result", result_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul_neg",   3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
        run_op("mulhu_m1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 34);
        run_op("mulh_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 34);
        run_op("mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34);
        run_op("div_neg",   3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34);
        run_op("rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34);
        run_op("divu",      3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       34);
        run_op("remu",      3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        34);
        run_op("div_zero",  3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
        run_op("rem_zero",  3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        1);
        run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
        run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);
        run_op("mul_x0",    3'b000, 32'd3,        32'd4,        5'd0,  32'd12,       34);

        // start pulse during CALC must be ignored
        funct3_i = 3'b000; rs1_data_i = 32'd6; rs2_data_i = 32'd7; rd_addr_i = 5'd9;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        funct3_i = 3'b101; rs1_data_i = 32'd1; rs2_data_i = 32'd0; rd_addr_i = 5'd3;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        dones = 0; res = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_o) begin
                dones++;
                res = result_o;
            end
        end
        $display("op start_ignore f3=0 a=6 b=7 result=%h dones=%0d", res, dones);
        check("start_ignore.dones", dones, 32'd1);
        check("start_ignore.result", res, 32'd42);

        // reset mid-operation at iteration 10
        funct3_i = 3'b011; rs1_data_i = 32'h12345678; rs2_data_i = 32'h9ABCDEF0; rd_addr_i = 5'd4;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(busy_o), 32'd0);
        check("abort.done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr_en_o) wr_cnt++;
        end
        $display("op abort f3=3 writes_after_reset=%0d", wr_cnt);
        check("abort.no_write", wr_cnt, 32'd0);

        run_op("mulhu_after_rst", 3'b011, 32'h00010000, 32'h00010000, 5'd21, 32'h00000001, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
